// File: rtl/instruction_queue_decoder.sv
// Instruction decoder with a DEPTH-entry FIFO between the processor bus and the video control unit.
// Strobed words are validated and split into opcode/register/data, then popped via valid/ready.
module instruction_queue_decoder #(
    parameter int DATA_W      = 32,
    parameter int OPCODE_W    = 2,
    parameter int REG_W       = 5,
    parameter int NUM_OPCODES = 3,
    parameter int DEPTH       = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             dataA,
    input  logic [DATA_W-1:0]       dataB,
    input  logic                    wr_en,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    valid,
    input  logic                    ready,
    output logic [OPCODE_W-1:0]     opcode,
    output logic [REG_W-1:0]        register,
    output logic [DATA_W-1:0]       data,
    output logic                    illegal,
    output logic                    overflow,
    output logic [7:0]              err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [OPCODE_W:0] LP_NUM_OPS = NUM_OPCODES[OPCODE_W:0];

    typedef struct packed {
        logic [OPCODE_W-1:0] op;
        logic [REG_W-1:0]    rg;
        logic [DATA_W-1:0]   dat;
    } entry_t;

    entry_t              r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_illegal;
    logic                r_overflow;
    logic [7:0]          r_err_count;

    logic [OPCODE_W-1:0] w_op;
    logic                w_legal;
    logic                w_full;
    logic                w_valid;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    entry_t              w_head;
    logic                w_unused;

    assign w_op     = dataA[OPCODE_W-1:0];
    assign w_legal  = {1'b0, w_op} < LP_NUM_OPS;
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_valid  = (r_count != '0);
    // A full FIFO rejects the strobe even if a pop frees a slot on the same edge.
    assign w_push   = wr_en & ~w_full & w_legal;
    assign w_pop    = w_valid & ready;
    assign w_drop   = wr_en & (w_full | ~w_legal);
    assign w_unused = ^dataA;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_illegal   <= 1'b0;
            r_overflow  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_overflow <= wr_en & w_full;
            r_illegal  <= wr_en & ~w_full & ~w_legal;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= '{op: w_op, rg: dataA[4+REG_W-1:4], dat: dataB};
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign valid     = w_valid;
    assign full      = w_full;
    assign count     = r_count;
    assign opcode    = w_valid ? w_head.op  : '0;
    assign register  = w_valid ? w_head.rg  : '0;
    assign data      = w_valid ? w_head.dat : '0;
    assign illegal   = r_illegal;
    assign overflow  = r_overflow;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_instruction_queue_decoder.sv
// Randomised and directed bench for instruction_queue_decoder against a queue-based model.
module tb_instruction_queue_decoder;

    localparam int DATA_W      = 32;
    localparam int OPCODE_W    = 2;
    localparam int REG_W       = 5;
    localparam int NUM_OPCODES = 3;
    localparam int DEPTH       = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [31:0]         dataA;
    logic [DATA_W-1:0]   dataB;
    logic                wr_en;
    logic                ready;
    logic                full;
    logic [2:0]          count;
    logic                valid;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    register;
    logic [DATA_W-1:0]   data;
    logic                illegal;
    logic                overflow;
    logic [7:0]          err_count;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rg;
        logic [31:0] dat;
    } ent_t;

    ent_t q[$];
    int   m_err = 0;
    bit   m_ill = 0;
    bit   m_ovf = 0;

    instruction_queue_decoder #(
        .DATA_W(DATA_W), .OPCODE_W(OPCODE_W), .REG_W(REG_W),
        .NUM_OPCODES(NUM_OPCODES), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .wr_en(wr_en),
        .full(full), .count(count), .valid(valid), .ready(ready),
        .opcode(opcode), .register(register), .data(data),
        .illegal(illegal), .overflow(overflow), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] e_op();
        return (q.size() != 0) ? q[0].op : 2'd0;
    endfunction
    function automatic logic [4:0] e_rg();
        return (q.size() != 0) ? q[0].rg : 5'd0;
    endfunction
    function automatic logic [31:0] e_dat();
        return (q.size() != 0) ? q[0].dat : 32'd0;
    endfunction

    // Drive one edge, advance the model from the pre-edge state, settle 1 time unit past the edge.
    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] b,
                        input logic r, input logic rst);
        ent_t e;
        bit   m_full;
        wr_en = w; dataA = a; dataB = b; ready = r; reset = rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_err = 0; m_ill = 0; m_ovf = 0;
        end else begin
            m_full = (q.size() == DEPTH);
            m_ovf  = w && m_full;
            m_ill  = w && !m_full && (int'(a[1:0]) >= NUM_OPCODES);
            if (q.size() != 0 && r) e = q.pop_front();
            if (w && !m_ovf && !m_ill) begin
                e.op = a[1:0]; e.rg = a[8:4]; e.dat = b;
                q.push_back(e);
            end
            if ((m_ovf || m_ill) && m_err < 255) m_err++;
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] legal_a(input int op);
        logic [31:0] a;
        a = $urandom;
        a[1:0] = 2'(op);
        return a;
    endfunction

    task automatic test_reset();
        step(1'b1, 32'h151, 32'h1, 1'b1, 1'b1);
        step(1'b1, 32'h151, 32'h1, 1'b1, 1'b1);
        n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", valid); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full got %0b exp 0", full); else n_pass++;
        n_total++; if ({illegal, overflow} !== 2'b00) $display("FAIL reset_pulses got %0b exp 0", {illegal, overflow}); else n_pass++;
        n_total++; if (err_count !== 8'd0) $display("FAIL reset_err got %0d exp 0", err_count); else n_pass++;
        n_total++; if ({opcode, register, data} !== '0) $display("FAIL reset_fields got %0h exp 0", {opcode, register, data}); else n_pass++;
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_single_push();
        step(1'b1, 32'h0000_0151, 32'h0012_0034, 1'b0, 1'b0);
        n_total++; if (valid !== 1'b1) $display("FAIL single_valid got %0b exp 1", valid); else n_pass++;
        n_total++; if (opcode !== 2'd1) $display("FAIL single_opcode got %0h exp 1", opcode); else n_pass++;
        n_total++; if (register !== 5'h15) $display("FAIL single_register got %0h exp 15", register); else n_pass++;
        n_total++; if (data !== 32'h0012_0034) $display("FAIL single_data got %0h exp 120034", data); else n_pass++;
        n_total++; if (count !== 3'd1) $display("FAIL single_count got %0d exp 1", count); else n_pass++;
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        n_total++; if (valid !== 1'b0) $display("FAIL single_pop_valid got %0b exp 0", valid); else n_pass++;
        n_total++; if ({opcode, register, data} !== '0) $display("FAIL single_pop_fields got %0h exp 0", {opcode, register, data}); else n_pass++;
    endtask

    task automatic test_fill_overflow();
        int          ops[4] = '{0, 1, 2, 0};
        logic [31:0] pd[4];
        logic [31:0] pa[4];
        for (int i = 0; i < 4; i++) begin
            pa[i] = legal_a(ops[i]);
            pd[i] = $urandom;
            step(1'b1, pa[i], pd[i], 1'b0, 1'b0);
        end
        n_total++; if (full !== 1'b1) $display("FAIL fill_full got %0b exp 1", full); else n_pass++;
        n_total++; if (count !== 3'd4) $display("FAIL fill_count got %0d exp 4", count); else n_pass++;
        step(1'b1, legal_a(1), 32'hDEAD_BEEF, 1'b0, 1'b0);
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_pulse got %0b exp 1", overflow); else n_pass++;
        n_total++; if (illegal !== 1'b0) $display("FAIL ovf_no_illegal got %0b exp 0", illegal); else n_pass++;
        n_total++; if (err_count !== 8'd1) $display("FAIL ovf_err got %0d exp 1", err_count); else n_pass++;
        n_total++; if (count !== 3'd4) $display("FAIL ovf_count got %0d exp 4", count); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (data !== pd[i]) $display("FAIL order_data%0d got %0h exp %0h", i, data, pd[i]); else n_pass++;
            n_total++; if (opcode !== 2'(ops[i]) || register !== pa[i][8:4])
                $display("FAIL order_fields%0d got %0h/%0h exp %0h/%0h", i, opcode, register, ops[i], pa[i][8:4]); else n_pass++;
            step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
            if (i == 0) begin
                n_total++; if (overflow !== 1'b0) $display("FAIL ovf_one_cycle got %0b exp 0", overflow); else n_pass++;
            end
        end
        n_total++; if (valid !== 1'b0) $display("FAIL drain_valid got %0b exp 0", valid); else n_pass++;
    endtask

    task automatic test_illegal();
        int e0;
        step(1'b1, legal_a(2), $urandom, 1'b0, 1'b0);
        e0 = m_err;
        step(1'b1, legal_a(3), $urandom, 1'b0, 1'b0);
        n_total++; if (illegal !== 1'b1) $display("FAIL illegal_pulse got %0b exp 1", illegal); else n_pass++;
        n_total++; if (count !== 3'd1) $display("FAIL illegal_count got %0d exp 1", count); else n_pass++;
        n_total++; if (int'(err_count) !== e0 + 1) $display("FAIL illegal_err got %0d exp %0d", err_count, e0 + 1); else n_pass++;
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_total++; if (illegal !== 1'b0) $display("FAIL illegal_one_cycle got %0b exp 0", illegal); else n_pass++;
        n_total++; if (opcode !== 2'd2) $display("FAIL illegal_head_op got %0h exp 2", opcode); else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        int e0;
        step(1'b1, legal_a($urandom_range(0, 2)), $urandom, 1'b0, 1'b0);
        step(1'b1, legal_a($urandom_range(0, 2)), $urandom, 1'b0, 1'b0);
        e0 = m_err;
        for (int i = 0; i < 10; i++) begin
            n_total++; if (data !== e_dat()) $display("FAIL b2b_data%0d got %0h exp %0h", i, data, e_dat()); else n_pass++;
            step(1'b1, legal_a($urandom_range(0, 2)), $urandom, 1'b1, 1'b0);
            n_total++; if (count !== 3'd2) $display("FAIL b2b_count%0d got %0d exp 2", i, count); else n_pass++;
        end
        n_total++; if (int'(err_count) !== e0) $display("FAIL b2b_no_drop got %0d exp %0d", err_count, e0); else n_pass++;
        drain();
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 4; i++) step(1'b1, legal_a(i % 3), $urandom, 1'b0, 1'b0);
        step(1'b1, legal_a(0), $urandom, 1'b1, 1'b0);
        n_total++; if (overflow !== 1'b1) $display("FAIL simul_ovf got %0b exp 1", overflow); else n_pass++;
        n_total++; if (count !== 3'd3) $display("FAIL simul_count got %0d exp 3", count); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL simul_full got %0b exp 0", full); else n_pass++;
        n_total++; if (data !== e_dat()) $display("FAIL simul_head got %0h exp %0h", data, e_dat()); else n_pass++;
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 6), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            n_total++; if (int'(count) !== q.size()) $display("FAIL rnd_count%0d got %0d exp %0d", i, count, q.size()); else n_pass++;
            n_total++; if (valid !== (q.size() != 0) || full !== (q.size() == DEPTH))
                $display("FAIL rnd_flags%0d got %0b%0b exp %0b%0b", i, valid, full, q.size() != 0, q.size() == DEPTH); else n_pass++;
            n_total++; if ({opcode, register, data} !== {e_op(), e_rg(), e_dat()})
                $display("FAIL rnd_head%0d got %0h exp %0h", i, {opcode, register, data}, {e_op(), e_rg(), e_dat()}); else n_pass++;
            n_total++; if ({illegal, overflow} !== {m_ill, m_ovf})
                $display("FAIL rnd_pulses%0d got %0b exp %0b", i, {illegal, overflow}, {m_ill, m_ovf}); else n_pass++;
            n_total++; if (int'(err_count) !== m_err) $display("FAIL rnd_err%0d got %0d exp %0d", i, err_count, m_err); else n_pass++;
        end
        drain();
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 300; i++) step(1'b1, legal_a(3), $urandom, 1'b0, 1'b0);
        n_total++; if (err_count !== 8'd255) $display("FAIL sat_err got %0d exp 255", err_count); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL sat_count got %0d exp 0", count); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) step(1'b1, legal_a(1), $urandom, 1'b0, 1'b0);
        n_total++; if (count !== 3'd3) $display("FAIL mid_pre_count got %0d exp 3", count); else n_pass++;
        step(1'b1, legal_a(1), $urandom, 1'b1, 1'b1);
        n_total++; if (count !== 3'd0) $display("FAIL mid_count got %0d exp 0", count); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL mid_valid got %0b exp 0", valid); else n_pass++;
        n_total++; if (err_count !== 8'd0) $display("FAIL mid_err got %0d exp 0", err_count); else n_pass++;
        n_total++; if (data !== 32'd0) $display("FAIL mid_data got %0h exp 0", data); else n_pass++;
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_total++; if (valid !== 1'b0) $display("FAIL mid_post_valid got %0b exp 0", valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_illegal();
        test_back_to_back();
        test_full_simul();
        test_random();
        test_err_saturate();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
